// File: rtl/led_pkg.sv
// Shared types, frame constants and helpers for the APA102/SK9822 strip driver.
// LED_PIX_BRIGHT_EN widens pixels to carry a per-pixel 5-bit brightness.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_WAIT,
    START_FRM,
    LED_FRM,
    END_FRM,
    POST_WAIT
  } led_tx_state_t;

  localparam logic [2:0]  LED_HDR    = 3'b111;
  localparam logic [31:0] START_WORD = 32'h0;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;

`ifdef LED_PIX_BRIGHT_EN
  localparam int unsigned PIX_W = 29;
`else
  localparam int unsigned PIX_W = 24;
`endif

  // End frame must supply at least n/2 clock edges to flush the chain.
  function automatic int unsigned end_words(input int unsigned n);
    return (n >> 6) + 1;
  endfunction

  // Wire format is header, brightness, then B, G, R from a packed {R,G,B}.
  function automatic logic [31:0] led_word(input logic [4:0] br, input logic [23:0] rgb);
    return {LED_HDR, br, rgb[7:0], rgb[15:8], rgb[23:16]};
  endfunction

endpackage

// File: rtl/led_strip_tx_bit_clk.sv
// Bit-period divider: one bit per 2*DIV_CNT cycles, registered cko level.
module led_bit_clk #(
  parameter int unsigned DIV_CNT = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic cko_en,
  output logic cko_level,
  output logic bit_start,
  output logic bit_last
);

  localparam int unsigned CW = (2 * DIV_CNT > 1) ? $clog2(2 * DIV_CNT) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  assign bit_start = (cnt == '0);
  assign bit_last  = (cnt == CW'(2 * DIV_CNT - 1));

  always_comb begin
    cnt_nx = cnt + CW'(1);
    if (!run || bit_last) cnt_nx = '0;
  end

  // cko tracks the counter value it will be paired with, so it is never late.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      cko_level <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      cko_level <= run && cko_en && (cnt_nx >= CW'(DIV_CNT));
    end
  end

endmodule

// File: rtl/led_strip_tx.sv
// APA102/SK9822 strip driver: CH data lanes on one shared cko, run-time LED count.
// Optional LED_PIX_BRIGHT_EN takes the header brightness from each pixel.
module led_strip_tx
  import led_pkg::*;
#(
  parameter  int unsigned MAX_LED  = 1024,
  parameter  int unsigned CH       = 1,
  parameter  int unsigned DIV_CNT  = 5,
  parameter  int unsigned WAIT_CNT = 5,
  localparam int unsigned LW       = $clog2(MAX_LED + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [LW-1:0]       led_num,
  input  logic [4:0]          brightness,
  input  logic [CH*PIX_W-1:0] pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                busy,
  output logic                done,
  output logic                underrun,
  output logic                cko,
  output logic [CH-1:0]       sdo
);

  localparam int unsigned WW = (WAIT_CNT > 1) ? $clog2(WAIT_CNT) : 1;

  led_tx_state_t         state, nx_state;
  logic [WW-1:0]         wait_cnt, nx_wait_cnt;
  logic [4:0]            bit_idx, nx_bit_idx;
  logic [LW-1:0]         word_cnt, nx_word_cnt;
  logic [LW-1:0]         acc_cnt, nx_acc_cnt;
  logic [LW-1:0]         n_led, nx_n_led;
  logic [LW-1:0]         n_end, nx_n_end;
  logic [4:0]            bright, nx_bright;
  logic                  pend_vld, nx_pend_vld;
  logic [CH*PIX_W-1:0]   pend_data, nx_pend_data;
  logic [CH-1:0][31:0]   shreg, nx_shreg;
  logic [CH-1:0]         nx_sdo;
  logic                  nx_ready, nx_busy, nx_done, nx_underrun;

  logic                  run_c, frame_c, bit_start, bit_last;
  logic                  load_led_c, accept_c;
  logic [LW-1:0]         led_clamp_c;
  logic [CH-1:0][31:0]   led_words_c;

  assign run_c   = (state != IDLE);
  assign frame_c = (state == START_FRM) || (state == LED_FRM) || (state == END_FRM);

  led_bit_clk #(.DIV_CNT(DIV_CNT)) u_bit_clk (
    .clk       (clk),
    .rstn      (rstn),
    .run       (run_c),
    .cko_en    (frame_c),
    .cko_level (cko),
    .bit_start (bit_start),
    .bit_last  (bit_last)
  );

  assign led_clamp_c = (led_num > LW'(MAX_LED)) ? LW'(MAX_LED) : led_num;
  assign accept_c    = pix_valid && pix_ready;

  // Next LED word per lane; an empty pending register yields a dark underrun word.
  always_comb begin
    led_words_c = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (pend_vld) begin
`ifdef LED_PIX_BRIGHT_EN
        led_words_c[i] = led_word(pend_data[i*PIX_W+24 +: 5], pend_data[i*PIX_W +: 24]);
`else
        led_words_c[i] = led_word(bright, pend_data[i*PIX_W +: 24]);
`endif
      end else begin
        led_words_c[i] = {LED_HDR, bright, 24'h0};
      end
    end
  end

  always_comb begin
    nx_state     = state;
    nx_wait_cnt  = wait_cnt;
    nx_bit_idx   = bit_idx;
    nx_word_cnt  = word_cnt;
    nx_acc_cnt   = acc_cnt;
    nx_n_led     = n_led;
    nx_n_end     = n_end;
    nx_bright    = bright;
    nx_pend_vld  = pend_vld;
    nx_pend_data = pend_data;
    nx_shreg     = shreg;
    nx_sdo       = sdo;
    nx_underrun  = underrun;
    nx_done      = 1'b0;
    load_led_c   = 1'b0;

    case (state)
      IDLE: begin
        // The divider is parked at zero in IDLE, so a bit period starts cleanly.
        if (start && bit_start) begin
          nx_state    = PRE_WAIT;
          nx_n_led    = led_clamp_c;
          nx_n_end    = LW'(end_words(32'(led_clamp_c)));
          nx_bright   = brightness;
          nx_underrun = 1'b0;
          nx_wait_cnt = '0;
          nx_acc_cnt  = '0;
          nx_pend_vld = 1'b0;
        end
      end
      PRE_WAIT: begin
        if (bit_last) begin
          if (wait_cnt == WW'(WAIT_CNT - 1)) begin
            nx_state   = START_FRM;
            nx_bit_idx = '0;
            nx_shreg   = {CH{START_WORD}};
            nx_sdo     = '0;
          end else begin
            nx_wait_cnt = wait_cnt + WW'(1);
          end
        end
      end
      START_FRM, LED_FRM, END_FRM: begin
        if (bit_last) begin
          if (bit_idx != 5'd31) begin
            nx_bit_idx = bit_idx + 5'd1;
            for (int i = 0; i < int'(CH); i++) begin
              nx_shreg[i] = {shreg[i][30:0], 1'b0};
              nx_sdo[i]   = shreg[i][30];
            end
          end else begin
            nx_bit_idx = '0;
            if ((state == START_FRM && n_led != '0) ||
                (state == LED_FRM && word_cnt != n_led - LW'(1))) begin
              nx_state    = LED_FRM;
              nx_word_cnt = (state == START_FRM) ? '0 : word_cnt + LW'(1);
              load_led_c  = 1'b1;
            end else if (state != END_FRM || word_cnt != n_end - LW'(1)) begin
              nx_state    = END_FRM;
              nx_word_cnt = (state == END_FRM) ? word_cnt + LW'(1) : '0;
              nx_shreg    = {CH{END_WORD}};
              nx_sdo      = '1;
              nx_pend_vld = 1'b0;
            end else begin
              nx_state    = POST_WAIT;
              nx_wait_cnt = '0;
              nx_sdo      = '1;
            end
          end
        end
      end
      POST_WAIT: begin
        if (bit_last) begin
          if (wait_cnt == WW'(WAIT_CNT - 1)) begin
            nx_state = IDLE;
            nx_done  = 1'b1;
          end else begin
            nx_wait_cnt = wait_cnt + WW'(1);
          end
        end
      end
      default: nx_state = IDLE;
    endcase

    if (load_led_c) begin
      nx_shreg = led_words_c;
      for (int i = 0; i < int'(CH); i++) nx_sdo[i] = led_words_c[i][31];
      if (!pend_vld) nx_underrun = 1'b1;
      nx_pend_vld = 1'b0;
    end

    // A word accepted on a load cycle lands in pending after the load.
    if (accept_c) begin
      nx_pend_vld  = 1'b1;
      nx_pend_data = pix_data;
      nx_acc_cnt   = acc_cnt + LW'(1);
    end

    nx_busy  = (nx_state != IDLE);
    nx_ready = ((nx_state == START_FRM) || (nx_state == LED_FRM)) &&
               !nx_pend_vld && (nx_acc_cnt < nx_n_led);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bit_idx   <= '0;
      word_cnt  <= '0;
      acc_cnt   <= '0;
      n_led     <= '0;
      n_end     <= '0;
      bright    <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      shreg     <= '0;
      sdo       <= '1;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= nx_state;
      wait_cnt  <= nx_wait_cnt;
      bit_idx   <= nx_bit_idx;
      word_cnt  <= nx_word_cnt;
      acc_cnt   <= nx_acc_cnt;
      n_led     <= nx_n_led;
      n_end     <= nx_n_end;
      bright    <= nx_bright;
      pend_vld  <= nx_pend_vld;
      pend_data <= nx_pend_data;
      shreg     <= nx_shreg;
      sdo       <= nx_sdo;
      pix_ready <= nx_ready;
      busy      <= nx_busy;
      done      <= nx_done;
      underrun  <= nx_underrun;
    end
  end

endmodule
